// File: rtl/count_sequencer_pkg.sv
// Shared types and default widths for the count sequencer.
package count_seq_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned RPT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : count_seq_pkg

// File: rtl/count_sequencer_if.sv
// Command / status bundle between a control master and the count sequencer.
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RPT_W = RPT_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic [RPT_W-1:0] cmd_repeat;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic [RPT_W-1:0] passes_left;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_repeat, abort,
    input  cmd_ready, count, busy, passes_left, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_repeat, abort,
    output cmd_ready, count, busy, passes_left, done, aborted
  );

endinterface : count_sequencer_if

// File: rtl/count_sequencer_load_upcounter.sv
// Synchronous loadable up counter; load beats enable, wraps modulo 2^WIDTH.
module load_upcounter
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load value, increment, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : load_upcounter

// File: rtl/count_sequencer.sv
// Command-driven sequencer that owns load/enable of an up counter and
// runs start..end passes with optional repeats, abort and completion pulses.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RPT_W = RPT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  count_sequencer_if.slave bus
);

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] start_q,     start_d;
  logic [WIDTH-1:0] end_q,       end_d;
  logic [RPT_W-1:0] passes_q,    passes_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             aborted_q,   aborted_d;

  logic             ctr_load_c;
  logic             ctr_en_c;
  logic             at_end_c;
  logic [WIDTH-1:0] count_w;

  // Counter datapath; its load and enable come only from the FSM below.
  load_upcounter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load_c),
    .en    (ctr_en_c),
    .d     (start_q),
    .count (count_w)
  );

  assign at_end_c = (count_w == end_q);

  // Next-state, command capture, pass bookkeeping and counter control.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    passes_d   = passes_q;
    aborted_d  = 1'b0;
    ctr_load_c = 1'b0;
    ctr_en_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Abort is meaningless here; a coincident command is still taken.
        if (bus.cmd_valid) begin
          start_d  = bus.cmd_start;
          end_d    = bus.cmd_end;
          passes_d = bus.cmd_repeat;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          passes_d  = '0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          ctr_load_c = 1'b1;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        // Abort wins over reaching the end value in the same cycle.
        if (bus.abort) begin
          passes_d  = '0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (at_end_c) begin
          if (passes_q != '0) begin
            passes_d = passes_q - RPT_W'(1);
            state_d  = LOAD;
          end else begin
            state_d  = DONE;
          end
        end else begin
          ctr_en_c = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d == LOAD) || (state_d == COUNT);
    done_d      = (state_d == DONE);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      passes_q    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      end_q       <= end_d;
      passes_q    <= passes_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.count       = count_w;
  assign bus.busy        = busy_q;
  assign bus.passes_left = passes_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer.
module tb_count_sequencer;
  import count_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  count_sequencer_if #(.WIDTH(4), .RPT_W(4)) bus ();

  count_sequencer #(.WIDTH(4), .RPT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one edge; returns in the cycle after acceptance.
  task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic [3:0] r);
    bus.cmd_start  = s;
    bus.cmd_end    = e;
    bus.cmd_repeat = r;
    bus.cmd_valid  = 1'b1;
    step();
    bus.cmd_valid  = 1'b0;
  endtask

  logic [3:0] wrap_exp [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_start  = '0;
    bus.cmd_end    = '0;
    bus.cmd_repeat = '0;
    bus.abort      = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_count",   32'(bus.count),       32'd0);
    chk("rst_ready",   32'(bus.cmd_ready),   32'd1);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_done",    32'(bus.done),        32'd0);
    chk("rst_aborted", 32'(bus.aborted),     32'd0);
    chk("rst_passes",  32'(bus.passes_left), 32'd0);

    // Single pass 3..6
    issue(4'd3, 4'd6, 4'd0);
    chk("sp_load_busy",  32'(bus.busy),      32'd1);
    chk("sp_load_ready", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sp_count", 32'(bus.count), 32'(3 + i));
      chk("sp_nodone", 32'(bus.done), 32'd0);
    end
    step();
    chk("sp_done",       32'(bus.done),      32'd1);
    chk("sp_done_count", 32'(bus.count),     32'd6);
    chk("sp_done_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    chk("sp_idle_done",  32'(bus.done),      32'd0);
    chk("sp_idle_ready", 32'(bus.cmd_ready), 32'd1);

    // Wrap pass 14..1
    issue(4'd14, 4'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_count", 32'(bus.count), 32'(wrap_exp[i]));
    end
    step();
    chk("wrap_done", 32'(bus.done), 32'd1);

    // Next command held during DONE, accepted in the first IDLE cycle
    bus.cmd_start  = 4'd9;
    bus.cmd_end    = 4'd9;
    bus.cmd_repeat = 4'd0;
    bus.cmd_valid  = 1'b1;
    step();
    chk("b2b_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("b2b_idle_busy",  32'(bus.busy),      32'd0);
    chk("b2b_idle_done",  32'(bus.done),      32'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("b2b_load_busy",  32'(bus.busy),  32'd1);
    chk("b2b_load_hold",  32'(bus.count), 32'd1);
    step();
    chk("eq_count", 32'(bus.count), 32'd9);
    chk("eq_nodone", 32'(bus.done), 32'd0);
    step();
    chk("eq_done", 32'(bus.done), 32'd1);
    step();
    chk("eq_idle", 32'(bus.cmd_ready), 32'd1);

    // Three passes of 2..4
    issue(4'd2, 4'd4, 4'd2);
    for (int p = 0; p < 3; p++) begin
      chk("rp_load_busy",   32'(bus.busy),        32'd1);
      chk("rp_load_passes", 32'(bus.passes_left), 32'(2 - p));
      for (int i = 0; i < 3; i++) begin
        step();
        chk("rp_count", 32'(bus.count), 32'(2 + i));
        chk("rp_nodone", 32'(bus.done), 32'd0);
      end
      step();
    end
    chk("rp_done",   32'(bus.done),        32'd1);
    chk("rp_passes", 32'(bus.passes_left), 32'd0);
    step();
    chk("rp_idle", 32'(bus.cmd_ready), 32'd1);

    // Abort mid-count at count=5
    issue(4'd3, 4'd10, 4'd3);
    step();
    step();
    step();
    chk("ab_pre_count", 32'(bus.count), 32'd5);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_aborted", 32'(bus.aborted),     32'd1);
    chk("ab_nodone",  32'(bus.done),        32'd0);
    chk("ab_count",   32'(bus.count),       32'd5);
    chk("ab_ready",   32'(bus.cmd_ready),   32'd1);
    chk("ab_busy",    32'(bus.busy),        32'd0);
    chk("ab_passes",  32'(bus.passes_left), 32'd0);
    step();
    chk("ab_pulse_end", 32'(bus.aborted), 32'd0);
    chk("ab_hold",      32'(bus.count),   32'd5);
    chk("ab_nodone2",   32'(bus.done),    32'd0);

    // Abort in IDLE together with a command: command wins
    bus.abort = 1'b1;
    issue(4'd7, 4'd7, 4'd0);
    bus.abort = 1'b0;
    chk("ai_busy",    32'(bus.busy),    32'd1);
    chk("ai_aborted", 32'(bus.aborted), 32'd0);
    step();
    chk("ai_count", 32'(bus.count), 32'd7);
    step();
    chk("ai_done", 32'(bus.done), 32'd1);
    step();

    // Reset while counting at count=4
    issue(4'd1, 4'd8, 4'd1);
    step();
    step();
    step();
    step();
    chk("rm_pre_count", 32'(bus.count), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_count",   32'(bus.count),       32'd0);
    chk("rm_ready",   32'(bus.cmd_ready),   32'd1);
    chk("rm_busy",    32'(bus.busy),        32'd0);
    chk("rm_done",    32'(bus.done),        32'd0);
    chk("rm_aborted", 32'(bus.aborted),     32'd0);
    chk("rm_passes",  32'(bus.passes_left), 32'd0);
    step();
    chk("rm_done2",    32'(bus.done),    32'd0);
    chk("rm_aborted2", 32'(bus.aborted), 32'd0);
    chk("rm_busy2",    32'(bus.busy),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_count_sequencer
